// File: rtl/packet_stream_arbiter.sv
// Packet-granular round-robin arbiter: merges N Avalon-ST sinks onto one registered source.
// Each forwarded beat carries its source index on the channel field.
module packet_stream_arbiter #(
  parameter int unsigned N_INPUTS      = 4,
  parameter int unsigned AST_DWIDTH    = 64,
  parameter int unsigned EMPTY_WIDTH   = $clog2(AST_DWIDTH/8),
  parameter int unsigned CHANNEL_WIDTH = $clog2(N_INPUTS)
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [N_INPUTS*AST_DWIDTH-1:0]    sink_data_i,
  input  logic [N_INPUTS-1:0]               sink_valid_i,
  input  logic [N_INPUTS-1:0]               sink_startofpacket_i,
  input  logic [N_INPUTS-1:0]               sink_endofpacket_i,
  input  logic [N_INPUTS*EMPTY_WIDTH-1:0]   sink_empty_i,
  output logic [N_INPUTS-1:0]               sink_ready_o,
  output logic [AST_DWIDTH-1:0]             src_data_o,
  output logic                              src_valid_o,
  output logic                              src_startofpacket_o,
  output logic                              src_endofpacket_o,
  output logic [EMPTY_WIDTH-1:0]            src_empty_o,
  output logic [CHANNEL_WIDTH-1:0]          src_channel_o,
  input  logic                              src_ready_i,
  output logic [15:0]                       drop_cnt_o
);

  localparam int unsigned CNT_WIDTH = 16;
  localparam int unsigned POP_WIDTH = $clog2(N_INPUTS + 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  typedef struct packed {
    logic                     sop;
    logic                     eop;
    logic [EMPTY_WIDTH-1:0]   empty;
    logic [CHANNEL_WIDTH-1:0] channel;
    logic [AST_DWIDTH-1:0]    data;
  } beat_t;

  state_e                   state_q, state_d;
  logic [CHANNEL_WIDTH-1:0] grant_q, grant_d;
  logic [CHANNEL_WIDTH-1:0] last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0]     drop_cnt_q, drop_cnt_d;
  logic                     valid_q, valid_d;
  beat_t                    beat_q, beat_d;

  logic                     can_load_c;
  logic                     accept_c;
  logic [N_INPUTS-1:0]      req_c;
  logic [N_INPUTS-1:0]      drop_c;
  logic [N_INPUTS-1:0]      ready_c;
  logic [POP_WIDTH-1:0]     drop_pop_c;
  logic [CNT_WIDTH:0]       drop_sum_c;
  logic                     rr_found_c;
  logic [CHANNEL_WIDTH-1:0] rr_idx_c;
  logic [CHANNEL_WIDTH-1:0] rr_k_c;

  logic [AST_DWIDTH-1:0]    data_arr  [N_INPUTS];
  logic [EMPTY_WIDTH-1:0]   empty_arr [N_INPUTS];

  for (genvar g = 0; g < N_INPUTS; g++) begin : g_unpack
    assign data_arr[g]  = sink_data_i[g*AST_DWIDTH +: AST_DWIDTH];
    assign empty_arr[g] = sink_empty_i[g*EMPTY_WIDTH +: EMPTY_WIDTH];
  end

  assign can_load_c = !valid_q | src_ready_i;
  assign req_c      = sink_valid_i & sink_startofpacket_i;
  assign drop_c     = sink_valid_i & ~sink_startofpacket_i;

  // Round-robin search for the first sop requester after the last packet owner.
  always_comb begin
    rr_found_c = 1'b0;
    rr_idx_c   = '0;
    rr_k_c     = '0;
    for (int unsigned i = 1; i <= N_INPUTS; i++) begin
      rr_k_c = CHANNEL_WIDTH'((32'(last_grant_q) + i) % N_INPUTS);
      if (!rr_found_c && req_c[rr_k_c]) begin
        rr_found_c = 1'b1;
        rr_idx_c   = rr_k_c;
      end
    end
  end

  always_comb begin
    drop_pop_c = '0;
    for (int unsigned i = 0; i < N_INPUTS; i++) begin
      drop_pop_c = drop_pop_c + POP_WIDTH'(drop_c[i]);
    end
    drop_sum_c = (CNT_WIDTH+1)'(drop_cnt_q) + (CNT_WIDTH+1)'(drop_pop_c);
  end

  // Next-state, ready and output-register load logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    drop_cnt_d   = drop_cnt_q;
    valid_d      = valid_q;
    beat_d       = beat_q;
    ready_c      = '0;
    accept_c     = 1'b0;

    case (state_q)
      IDLE: begin
        ready_c    = drop_c;
        drop_cnt_d = drop_sum_c[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : drop_sum_c[CNT_WIDTH-1:0];
        if (rr_found_c) begin
          grant_d = rr_idx_c;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        ready_c[grant_q] = can_load_c;
        accept_c         = sink_valid_i[grant_q] & can_load_c;
        if (accept_c && sink_endofpacket_i[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept_c) begin
      valid_d        = 1'b1;
      beat_d.sop     = sink_startofpacket_i[grant_q];
      beat_d.eop     = sink_endofpacket_i[grant_q];
      beat_d.empty   = empty_arr[grant_q];
      beat_d.channel = grant_q;
      beat_d.data    = data_arr[grant_q];
    end else if (src_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= CHANNEL_WIDTH'(N_INPUTS - 1);
      drop_cnt_q   <= '0;
      valid_q      <= 1'b0;
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      drop_cnt_q   <= drop_cnt_d;
      valid_q      <= valid_d;
      beat_q       <= beat_d;
    end
  end

  // Ready is combinational from can_load; held low while reset is asserted.
  assign sink_ready_o        = rst_n_i ? ready_c : '0;
  assign src_valid_o         = valid_q;
  assign src_data_o          = beat_q.data;
  assign src_startofpacket_o = beat_q.sop;
  assign src_endofpacket_o   = beat_q.eop;
  assign src_empty_o         = beat_q.empty;
  assign src_channel_o       = beat_q.channel;
  assign drop_cnt_o          = drop_cnt_q;

endmodule
